// File: rtl/xyz_trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xyz_trap_pkg
// Description : Shared definitions for machine-mode trap sequencing:
//               interrupt cause codes, mtvec modes and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package xyz_trap_pkg;

   // Interrupt cause codes (mcause[3:0] when the interrupt flag is set)
   localparam logic [3:0] CAUSE_MEI = 4'd11;
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   // mtvec[1:0] modes; the reserved modes (1x) behave as direct
   localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DRAIN    = 3'd1,
      ST_COMMIT   = 3'd2,
      ST_REDIRECT = 3'd3,
      ST_MRET     = 3'd4
   } trap_state_e;

endpackage : xyz_trap_pkg
`default_nettype wire

// File: rtl/trap_prio.sv
`default_nettype none
// ============================================================================
// Module      : trap_prio
// Description : Masks the machine interrupt pending lines with their enables
//               and a global gate, then priority-encodes MEI > MSI > MTI.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_prio
   import xyz_trap_pkg::*;
(
   input  logic       en_i,      // global gate (instruction valid and MIE)
   input  logic [2:0] pend_i,    // {meip, msip, mtip}
   input  logic [2:0] ena_i,     // {meie, msie, mtie}
   output logic       take_o,
   output logic [3:0] cause_o
);

   logic [2:0] masked;

   // Mask and priority-encode the pending interrupt lines
   always_comb begin
      masked  = pend_i & ena_i & {3{en_i}};
      take_o  = |masked;
      cause_o = 4'd0;
      if (masked[2]) begin
         cause_o = CAUSE_MEI;
      end else if (masked[1]) begin
         cause_o = CAUSE_MSI;
      end else if (masked[0]) begin
         cause_o = CAUSE_MTI;
      end
   end

endmodule : trap_prio
`default_nettype wire

// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trap_sequencer
// Description : Writeback-stage trap entry / mret sequencer. Arbitrates an
//               exception, the machine interrupts and mret, drains the data
//               bus, strobes the CSR trap update and redirects fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_sequencer
   import xyz_trap_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DRAIN_MAX = 16
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wb_valid_i,
   input  logic [XLEN-1:0] wb_pc_i,
   input  logic            exc_valid_i,
   input  logic [3:0]      exc_code_i,
   input  logic            mret_i,
   input  logic            int_meip_i,
   input  logic            int_msip_i,
   input  logic            int_mtip_i,
   input  logic            mstatus_mie_i,
   input  logic [2:0]      mie_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic            mem_busy_i,
   output logic            kill_wb_o,
   output logic            flush_o,
   output logic            csr_trap_we_o,
   output logic            csr_mret_o,
   output logic [XLEN-1:0] csr_cause_o,
   output logic [XLEN-1:0] csr_epc_o,
   output logic            redirect_valid_o,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            busy_o,
   output logic            drain_timeout_o
);

   localparam int             CNT_W    = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_MAX - 1);

   trap_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] epc_q, epc_d;
   logic [XLEN-1:0] target_q, target_d;
   logic            timeout_q, timeout_d;

   // Registered output copies, decoded from the next state
   logic            busy_q, busy_d;
   logic            flush_q, flush_d;
   logic            trap_we_q, trap_we_d;
   logic            mret_q, mret_d;
   logic            redir_q, redir_d;
   logic [XLEN-1:0] redir_pc_q, redir_pc_d;

   logic            int_take;
   logic [3:0]      int_cause;
   logic            accept_trap;
   logic            is_int;
   logic [3:0]      trap_code;
   logic [XLEN-1:0] vec_base;
   logic [XLEN-1:0] vec_offset;

   trap_prio u_prio (
      .en_i    (wb_valid_i & mstatus_mie_i),
      .pend_i  ({int_meip_i, int_msip_i, int_mtip_i}),
      .ena_i   (mie_i),
      .take_o  (int_take),
      .cause_o (int_cause)
   );

   // Next-state, latched trap context and next registered-output values
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cause_d     = cause_q;
      epc_d       = epc_q;
      target_d    = target_q;
      timeout_d   = timeout_q;
      accept_trap = 1'b0;
      is_int      = 1'b0;
      trap_code   = exc_code_i;
      vec_base    = {mtvec_i[XLEN-1:2], 2'b00};
      vec_offset  = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (exc_valid_i) begin
               accept_trap = 1'b1;
            end else if (int_take) begin
               accept_trap = 1'b1;
               is_int      = 1'b1;
               trap_code   = int_cause;
            end

            if (accept_trap) begin
               // Vectored mode only applies to interrupts
               if (is_int && (mtvec_i[1:0] == MTVEC_VECTORED)) begin
                  vec_offset = {{(XLEN-6){1'b0}}, trap_code, 2'b00};
               end
               cause_d  = {is_int, {(XLEN-5){1'b0}}, trap_code};
               epc_d    = wb_pc_i;
               target_d = vec_base + vec_offset;
               cnt_d    = CNT_LOAD;
               state_d  = ST_DRAIN;
            end else if (mret_i && wb_valid_i) begin
               target_d = mepc_i;
               state_d  = ST_MRET;
            end
         end
         ST_DRAIN: begin
            if (!mem_busy_i) begin
               state_d = ST_COMMIT;
            end else if (cnt_q == '0) begin
               timeout_d = 1'b1;
               state_d   = ST_COMMIT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_COMMIT:   state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_IDLE;
         ST_MRET:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      busy_d     = (state_d != ST_IDLE);
      flush_d    = (state_d == ST_DRAIN) || (state_d == ST_COMMIT) || (state_d == ST_MRET);
      trap_we_d  = (state_d == ST_COMMIT);
      mret_d     = (state_d == ST_MRET);
      redir_d    = (state_d == ST_REDIRECT) || (state_d == ST_MRET);
      redir_pc_d = redir_d ? target_d : '0;
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cause_q    <= '0;
         epc_q      <= '0;
         target_q   <= '0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
         flush_q    <= 1'b0;
         trap_we_q  <= 1'b0;
         mret_q     <= 1'b0;
         redir_q    <= 1'b0;
         redir_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         target_q   <= target_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
         flush_q    <= flush_d;
         trap_we_q  <= trap_we_d;
         mret_q     <= mret_d;
         redir_q    <= redir_d;
         redir_pc_q <= redir_pc_d;
      end
   end

   // Outputs are forced low while reset is held so no strobe escapes mid-sequence
   assign kill_wb_o        = accept_trap & ~rst_i;
   assign flush_o          = (flush_q | accept_trap) & ~rst_i;
   assign csr_trap_we_o    = trap_we_q & ~rst_i;
   assign csr_mret_o       = mret_q & ~rst_i;
   assign csr_cause_o      = rst_i ? '0 : cause_q;
   assign csr_epc_o        = rst_i ? '0 : epc_q;
   assign redirect_valid_o = redir_q & ~rst_i;
   assign redirect_pc_o    = rst_i ? '0 : redir_pc_q;
   assign busy_o           = busy_q & ~rst_i;
   assign drain_timeout_o  = timeout_q & ~rst_i;

endmodule : trap_sequencer
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_sequencer
// Description : Self-checking bench for trap_sequencer: directed cases then
//               randomized traps/mrets against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_sequencer;

   localparam int XLEN      = 32;
   localparam int DRAIN_MAX = 16;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            wb_valid_i;
   logic [XLEN-1:0] wb_pc_i;
   logic            exc_valid_i;
   logic [3:0]      exc_code_i;
   logic            mret_i;
   logic            int_meip_i, int_msip_i, int_mtip_i;
   logic            mstatus_mie_i;
   logic [2:0]      mie_i;
   logic [XLEN-1:0] mtvec_i;
   logic [XLEN-1:0] mepc_i;
   logic            mem_busy_i;
   logic            kill_wb_o, flush_o, csr_trap_we_o, csr_mret_o;
   logic [XLEN-1:0] csr_cause_o, csr_epc_o, redirect_pc_o;
   logic            redirect_valid_o, busy_o, drain_timeout_o;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic exp_to   = 1'b0;

   trap_sequencer #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .wb_valid_i       (wb_valid_i),
      .wb_pc_i          (wb_pc_i),
      .exc_valid_i      (exc_valid_i),
      .exc_code_i       (exc_code_i),
      .mret_i           (mret_i),
      .int_meip_i       (int_meip_i),
      .int_msip_i       (int_msip_i),
      .int_mtip_i       (int_mtip_i),
      .mstatus_mie_i    (mstatus_mie_i),
      .mie_i            (mie_i),
      .mtvec_i          (mtvec_i),
      .mepc_i           (mepc_i),
      .mem_busy_i       (mem_busy_i),
      .kill_wb_o        (kill_wb_o),
      .flush_o          (flush_o),
      .csr_trap_we_o    (csr_trap_we_o),
      .csr_mret_o       (csr_mret_o),
      .csr_cause_o      (csr_cause_o),
      .csr_epc_o        (csr_epc_o),
      .redirect_valid_o (redirect_valid_o),
      .redirect_pc_o    (redirect_pc_o),
      .busy_o           (busy_o),
      .drain_timeout_o  (drain_timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string ph, input logic kill, input logic flush,
                           input logic we, input logic mr, input logic rv,
                           input logic [31:0] rpc, input logic busy);
      chk({ph, ".kill"},  kill_wb_o,        kill);
      chk({ph, ".flush"}, flush_o,          flush);
      chk({ph, ".we"},    csr_trap_we_o,    we);
      chk({ph, ".mret"},  csr_mret_o,       mr);
      chk({ph, ".rv"},    redirect_valid_o, rv);
      chk({ph, ".rpc"},   redirect_pc_o,    rpc);
      chk({ph, ".busy"},  busy_o,           busy);
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      wb_valid_i    = 1'b0;
      wb_pc_i       = '0;
      exc_valid_i   = 1'b0;
      exc_code_i    = '0;
      mret_i        = 1'b0;
      int_meip_i    = 1'b0;
      int_msip_i    = 1'b0;
      int_mtip_i    = 1'b0;
      mstatus_mie_i = 1'b0;
      mie_i         = '0;
      mtvec_i       = '0;
      mepc_i        = '0;
      mem_busy_i    = 1'b0;
   endtask

   // Garbage on every input the sequencer must ignore outside IDLE
   task automatic scramble();
      wb_valid_i    = 1'($urandom);
      wb_pc_i       = $urandom;
      exc_valid_i   = 1'($urandom);
      exc_code_i    = 4'($urandom);
      mret_i        = 1'($urandom);
      int_meip_i    = 1'($urandom);
      int_msip_i    = 1'($urandom);
      int_mtip_i    = 1'($urandom);
      mstatus_mie_i = 1'($urandom);
      mie_i         = 3'($urandom);
      mtvec_i       = $urandom;
      mepc_i        = $urandom;
   endtask

   // Reference: kind 0 = nothing, 1 = trap, 2 = mret
   function automatic void model(input logic wbv, input logic exc, input logic [3:0] code,
                                 input logic mr, input logic [2:0] pend, input logic [2:0] ena,
                                 input logic gmie, input logic [31:0] mtvec, input logic [31:0] mepc,
                                 output int kind, output logic [31:0] cause, output logic [31:0] tgt);
      int prio_bit[3]  = '{2, 1, 0};
      int prio_code[3] = '{11, 3, 7};
      bit intr = 0;
      int icode = 0;
      kind  = 0;
      cause = 0;
      tgt   = 0;
      if (wbv && gmie) begin
         for (int i = 2; i >= 0; i--) begin
            if (pend[prio_bit[i]] && ena[prio_bit[i]]) begin
               intr  = 1;
               icode = prio_code[i];
            end
         end
      end
      if (exc) begin
         kind  = 1;
         cause = {28'd0, code};
         tgt   = mtvec & ~32'h3;
      end else if (intr) begin
         kind  = 1;
         cause = 32'h8000_0000 + icode;
         tgt   = (mtvec & ~32'h3) + ((mtvec[1:0] == 2'b01) ? 4 * icode : 0);
      end else if (mr && wbv) begin
         kind = 2;
         tgt  = mepc;
      end
   endfunction

   // One acceptance attempt, starting just after a rising edge in IDLE
   task automatic run_case(input string name, input logic wbv, input logic [31:0] pc,
                           input logic exc, input logic [3:0] code, input logic mr,
                           input logic [2:0] pend, input logic [2:0] ena, input logic gmie,
                           input logic [31:0] mtvec, input logic [31:0] mepc,
                           input int busy_n, input bit rst_commit);
      int          kind;
      int          dlen;
      logic [31:0] cause, tgt;
      wb_valid_i    = wbv;   wb_pc_i   = pc;
      exc_valid_i   = exc;   exc_code_i = code;
      mret_i        = mr;
      {int_meip_i, int_msip_i, int_mtip_i} = pend;
      mie_i         = ena;   mstatus_mie_i = gmie;
      mtvec_i       = mtvec; mepc_i   = mepc;
      mem_busy_i    = 1'b0;
      model(wbv, exc, code, mr, pend, ena, gmie, mtvec, mepc, kind, cause, tgt);

      @(negedge clk_i);
      chk_outs({name, ".acc"}, kind == 1, kind == 1, 0, 0, 0, 0, 0);
      next_cycle();

      if (kind == 2) begin
         scramble();
         @(negedge clk_i);
         chk_outs({name, ".mret"}, 0, 1, 0, 1, 1, tgt, 1);
         next_cycle();
      end else if (kind == 1) begin
         dlen = (busy_n >= DRAIN_MAX) ? DRAIN_MAX : busy_n + 1;
         for (int i = 0; i < dlen; i++) begin
            scramble();
            mem_busy_i = (i < busy_n);
            @(negedge clk_i);
            chk_outs({name, ".drain"}, 0, 1, 0, 0, 0, 0, 1);
            next_cycle();
         end
         if (busy_n >= DRAIN_MAX) exp_to = 1'b1;
         scramble();
         mem_busy_i = 1'($urandom);
         if (rst_commit) begin
            rst_i = 1'b1;
            @(negedge clk_i);
            chk_outs({name, ".rstc"}, 0, 0, 0, 0, 0, 0, 0);
            chk({name, ".rstc.cause"}, csr_cause_o, 0);
            chk({name, ".rstc.to"}, drain_timeout_o, 0);
            next_cycle();
            rst_i = 1'b0;
            exp_to = 1'b0;
            idle_inputs();
            @(negedge clk_i);
            chk_outs({name, ".rsti"}, 0, 0, 0, 0, 0, 0, 0);
            chk({name, ".rsti.cause"}, csr_cause_o, 0);
            chk({name, ".rsti.epc"}, csr_epc_o, 0);
            chk({name, ".rsti.to"}, drain_timeout_o, 0);
            next_cycle();
            return;
         end
         @(negedge clk_i);
         chk_outs({name, ".commit"}, 0, 1, 1, 0, 0, 0, 1);
         chk({name, ".cause"}, csr_cause_o, cause);
         chk({name, ".epc"}, csr_epc_o, pc);
         chk({name, ".timeout"}, drain_timeout_o, exp_to);
         next_cycle();
         scramble();
         @(negedge clk_i);
         chk_outs({name, ".redir"}, 0, 0, 0, 0, 1, tgt, 1);
         chk({name, ".cause_hold"}, csr_cause_o, cause);
         next_cycle();
      end

      idle_inputs();
      @(negedge clk_i);
      chk_outs({name, ".idle"}, 0, 0, 0, 0, 0, 0, 0);
      if (kind == 1) chk({name, ".epc_hold"}, csr_epc_o, pc);
      next_cycle();
   endtask

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      repeat (2) next_cycle();
      @(negedge clk_i);
      chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
      chk("reset.cause", csr_cause_o, 0);
      chk("reset.epc", csr_epc_o, 0);
      chk("reset.to", drain_timeout_o, 0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk_outs("idle0", 0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // Directed cases
      run_case("exc",      1, 32'h100, 1, 4'd2, 0, 3'b000, 3'b000, 0, 32'h800, 0, 0, 0);
      run_case("vec_mei",  1, 32'h200, 0, 4'd0, 0, 3'b100, 3'b100, 1, 32'h801, 0, 0, 0);
      run_case("prio_exc", 1, 32'h300, 1, 4'd5, 0, 3'b110, 3'b111, 1, 32'h801, 0, 0, 0);
      run_case("prio_msi", 1, 32'h304, 0, 4'd0, 0, 3'b011, 3'b111, 1, 32'h900, 0, 0, 0);
      run_case("vec_mti",  1, 32'h308, 0, 4'd0, 0, 3'b001, 3'b001, 1, 32'h1001, 0, 0, 0);
      run_case("no_gmie",  1, 32'h30C, 0, 4'd0, 0, 3'b111, 3'b111, 0, 32'h900, 0, 0, 0);
      run_case("no_wbv",   0, 32'h310, 0, 4'd0, 1, 3'b111, 3'b111, 1, 32'h900, 32'h44, 0, 0);
      run_case("drain4",   1, 32'h400, 1, 4'd7, 0, 3'b000, 3'b000, 0, 32'h800, 0, 3, 0);
      run_case("wdog",     1, 32'h404, 1, 4'd6, 0, 3'b000, 3'b000, 0, 32'h800, 0, 40, 0);
      run_case("sticky",   1, 32'h408, 1, 4'd4, 0, 3'b000, 3'b000, 0, 32'h800, 0, 0, 0);
      run_case("mret",     1, 32'h500, 0, 4'd0, 1, 3'b000, 3'b111, 1, 32'h800, 32'h240, 0, 0);
      run_case("mret_int", 1, 32'h504, 0, 4'd0, 1, 3'b001, 3'b001, 1, 32'h800, 32'h240, 0, 0);
      run_case("rst_cmt",  1, 32'h600, 1, 4'd1, 0, 3'b000, 3'b000, 0, 32'h800, 0, 2, 1);
      run_case("after_rst",1, 32'h604, 1, 4'd3, 0, 3'b000, 3'b000, 0, 32'hFFFF_FFFD, 0, 0, 0);

      // Randomized acceptance attempts
      for (int n = 0; n < 60; n++) begin
         run_case("rnd",
                  ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 3) == 0), 4'($urandom),
                  ($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom),
                  1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_trap_sequencer
`default_nettype wire
